// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//   Gshare conditional-branch predictor that sits beside fetch. The pattern
//   table is indexed by PC[INDEX_BITS+1:2] XOR global history. Each accepted
//   branch is pushed into an in-order queue until execute resolves it. A
//   resolve trains the counter of the oldest branch. A misprediction
//   restores the history from that entry and flushes every younger branch.
//
// Ports
//   i_saat            clock (rising edge)
//   i_reset           synchronous active-high reset
//   i_buyruk_gecerli  fetch word / PC valid
//   i_buyruk_sayaci   PC of fetched instruction
//   i_buyruk          fetched instruction word
//   o_buyruk_ongoru   prediction of last accepted branch (1 = taken)
//   o_ongoru_gecerli  one-cycle pulse: new prediction
//   i_sonuc_gecerli   oldest outstanding branch resolves this cycle
//   i_buyruk_atladi   actual outcome of that branch
//   o_ongoru_yanlis   one-cycle pulse: resolved branch was mispredicted
//   o_kuyruk_dolu     queue full; fetch must stall branches
module gshare_branch_predictor #(
  parameter int PHT_ENTRIES   = 64,
  parameter int GHR_WIDTH     = 6,
  parameter int COUNTER_WIDTH = 2,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic        i_saat,
  input  logic        i_reset,
  input  logic        i_buyruk_gecerli,
  input  logic [31:0] i_buyruk_sayaci,
  input  logic [31:0] i_buyruk,
  output logic        o_buyruk_ongoru,
  output logic        o_ongoru_gecerli,
  input  logic        i_sonuc_gecerli,
  input  logic        i_buyruk_atladi,
  output logic        o_ongoru_yanlis,
  output logic        o_kuyruk_dolu
);

  localparam int INDEX_BITS = $clog2(PHT_ENTRIES);
  localparam int PTR_BITS   = $clog2(QUEUE_DEPTH);
  localparam int CNT_BITS   = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0]      FULL_CNT = CNT_BITS'(QUEUE_DEPTH);
  localparam logic [COUNTER_WIDTH-1:0] CTR_INIT = {1'b0, {(COUNTER_WIDTH-1){1'b1}}};
  localparam logic [COUNTER_WIDTH-1:0] CTR_MAX  = '1;

  function automatic logic [COUNTER_WIDTH-1:0] sat_update(
    input logic [COUNTER_WIDTH-1:0] c, input logic taken);
    if (taken) return (c == CTR_MAX) ? c : c + COUNTER_WIDTH'(1);
    else       return (c == '0)      ? c : c - COUNTER_WIDTH'(1);
  endfunction

  function automatic logic [GHR_WIDTH-1:0] shift_in(
    input logic [GHR_WIDTH-1:0] g, input logic b);
    return (g << 1) | GHR_WIDTH'(b);
  endfunction

  logic [COUNTER_WIDTH-1:0] pht_q [PHT_ENTRIES];
  logic [COUNTER_WIDTH-1:0] pht_d [PHT_ENTRIES];
  logic [GHR_WIDTH-1:0]     ghr_q, ghr_d;
  logic [INDEX_BITS-1:0]    q_idx_q  [QUEUE_DEPTH];
  logic [INDEX_BITS-1:0]    q_idx_d  [QUEUE_DEPTH];
  logic                     q_pred_q [QUEUE_DEPTH];
  logic                     q_pred_d [QUEUE_DEPTH];
  logic [GHR_WIDTH-1:0]     q_ghr_q  [QUEUE_DEPTH];
  logic [GHR_WIDTH-1:0]     q_ghr_d  [QUEUE_DEPTH];
  logic [PTR_BITS-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_BITS-1:0]      count_q, count_d;
  logic                     pred_q, pred_d;
  logic                     pred_vld_q, pred_vld_d;
  logic                     mispred_q, mispred_d;

  logic                  is_branch, q_empty, q_full, resolve, mispredict, accept;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic                  lookup_pred;

  logic unused_bits;
  assign unused_bits = ^{i_buyruk[31:7], i_buyruk_sayaci[31:INDEX_BITS+2],
                         i_buyruk_sayaci[1:0]};

  // Lookup / resolve decode
  always_comb begin
    is_branch   = i_buyruk_gecerli && (i_buyruk[6:0] == 7'b1100011);
    q_empty     = (count_q == '0);
    q_full      = (count_q == FULL_CNT);
    resolve     = i_sonuc_gecerli && !q_empty;
    mispredict  = resolve && (i_buyruk_atladi != q_pred_q[head_q]);
    lookup_idx  = i_buyruk_sayaci[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    // Reads the pre-update counter even if this cycle's resolve trains it.
    lookup_pred = pht_q[lookup_idx][COUNTER_WIDTH-1];
    // A correct resolve frees its slot, so a full queue can still accept.
    accept      = is_branch && !mispredict && (!q_full || resolve);
  end

  // Next-state
  always_comb begin
    pht_d    = pht_q;
    ghr_d    = ghr_q;
    q_idx_d  = q_idx_q;
    q_pred_d = q_pred_q;
    q_ghr_d  = q_ghr_q;
    head_d   = head_q + PTR_BITS'(resolve);
    tail_d   = tail_q + PTR_BITS'(accept);
    count_d  = count_q + CNT_BITS'(accept) - CNT_BITS'(resolve);
    pred_d   = accept ? lookup_pred : pred_q;
    pred_vld_d = accept;
    mispred_d  = mispredict;

    if (resolve)
      pht_d[q_idx_q[head_q]] = sat_update(pht_q[q_idx_q[head_q]], i_buyruk_atladi);

    if (accept) begin
      q_idx_d[tail_q]  = lookup_idx;
      q_pred_d[tail_q] = lookup_pred;
      q_ghr_d[tail_q]  = ghr_q;
      ghr_d            = shift_in(ghr_q, lookup_pred);
    end

    if (mispredict) begin
      ghr_d   = shift_in(q_ghr_q[head_q], i_buyruk_atladi);
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state and pattern table
  always_ff @(posedge i_saat) begin
    if (i_reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CTR_INIT;
      ghr_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pred_q     <= 1'b0;
      pred_vld_q <= 1'b0;
      mispred_q  <= 1'b0;
    end else begin
      pht_q      <= pht_d;
      ghr_q      <= ghr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pred_q     <= pred_d;
      pred_vld_q <= pred_vld_d;
      mispred_q  <= mispred_d;
    end
  end

  // Queue payload; occupancy alone decides which slots are live.
  always_ff @(posedge i_saat) begin
    q_idx_q  <= q_idx_d;
    q_pred_q <= q_pred_d;
    q_ghr_q  <= q_ghr_d;
  end

  assign o_buyruk_ongoru  = pred_q;
  assign o_ongoru_gecerli = pred_vld_q;
  assign o_ongoru_yanlis  = mispred_q;
  assign o_kuyruk_dolu    = (count_q == FULL_CNT);

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor
//   Directed bench for gshare_branch_predictor. Stimulus pushes the expected
//   cycle/value of every prediction and mispredict pulse into queues; a
//   monitor thread pops and compares whenever the DUT pulses an output.
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_buyruk_gecerli = 1'b0;
  logic [31:0] i_buyruk_sayaci  = '0;
  logic [31:0] i_buyruk         = '0;
  logic        i_sonuc_gecerli  = 1'b0;
  logic        i_buyruk_atladi  = 1'b0;
  logic        o_buyruk_ongoru, o_ongoru_gecerli, o_ongoru_yanlis, o_kuyruk_dolu;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_pred_cyc[$];
  bit exp_pred_val[$];
  int exp_mis_cyc[$];

  gshare_branch_predictor #(
    .PHT_ENTRIES(64), .GHR_WIDTH(6), .COUNTER_WIDTH(2), .QUEUE_DEPTH(4)
  ) dut (
    .i_saat(clk), .i_reset(rst),
    .i_buyruk_gecerli(i_buyruk_gecerli), .i_buyruk_sayaci(i_buyruk_sayaci),
    .i_buyruk(i_buyruk),
    .o_buyruk_ongoru(o_buyruk_ongoru), .o_ongoru_gecerli(o_ongoru_gecerli),
    .i_sonuc_gecerli(i_sonuc_gecerli), .i_buyruk_atladi(i_buyruk_atladi),
    .o_ongoru_yanlis(o_ongoru_yanlis), .o_kuyruk_dolu(o_kuyruk_dolu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; inputs change #1 after the edge.
  task automatic drive(input logic bv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rv, input logic tk);
    i_buyruk_gecerli = bv;
    i_buyruk_sayaci  = pc;
    i_buyruk         = ins;
    i_sonuc_gecerli  = rv;
    i_buyruk_atladi  = tk;
    @(posedge clk); #1;
    i_buyruk_gecerli = 1'b0;
    i_sonuc_gecerli  = 1'b0;
    i_buyruk_atladi  = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic exp_pred(input bit p);
    exp_pred_cyc.push_back(cyc);
    exp_pred_val.push_back(p);
  endtask

  task automatic br(input logic [31:0] pc, input bit p);
    drive(1'b1, pc, 32'h0000_0063, 1'b0, 1'b0);
    exp_pred(p);
  endtask

  task automatic res(input bit tk, input bit mis);
    drive(1'b0, 32'h0, 32'h0, 1'b1, tk);
    if (mis) exp_mis_cyc.push_back(cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ongoru"},  {31'b0, o_buyruk_ongoru},  32'd0);
    chk({tag, "_gecerli"}, {31'b0, o_ongoru_gecerli}, 32'd0);
    chk({tag, "_yanlis"},  {31'b0, o_ongoru_yanlis},  32'd0);
    chk({tag, "_dolu"},    {31'b0, o_kuyruk_dolu},    32'd0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (o_ongoru_gecerli === 1'b1) begin
          if (exp_pred_cyc.size() == 0) begin
            checks++; errors++;
            $display("FAIL pred_pulse: got unexpected pulse, value %0b, expected none (cycle %0d)",
                     o_buyruk_ongoru, cyc);
          end else begin
            chk("pred_cycle", cyc, exp_pred_cyc.pop_front());
            chk("pred_value", {31'b0, o_buyruk_ongoru}, {31'b0, exp_pred_val.pop_front()});
          end
        end
        if (o_ongoru_yanlis === 1'b1) begin
          if (exp_mis_cyc.size() == 0) begin
            checks++; errors++;
            $display("FAIL mispredict_pulse: got unexpected pulse, expected none (cycle %0d)", cyc);
          end else begin
            chk("mispredict_cycle", cyc, exp_mis_cyc.pop_front());
          end
        end
      end
    join_none

    // 1: reset and first lookup
    rst = 1'b1; idle(); idle();
    check_reset_outputs("reset1");
    rst = 1'b0;
    br(32'h100, 1'b0);
    chk("t1_dolu", {31'b0, o_kuyruk_dolu}, 32'd0);
    drive(1'b1, 32'h104, 32'h0000_0013, 1'b0, 1'b0);
    chk("t1_nonbranch_no_pulse", {31'b0, o_ongoru_gecerli}, 32'd0);

    rst = 1'b1; idle(); idle(); rst = 1'b0;

    // 2: mispredict repair, ghr = 000001, counter[0] = 10
    br(32'h0, 1'b0);
    res(1'b1, 1'b1);
    chk("t2_dolu_after_flush", {31'b0, o_kuyruk_dolu}, 32'd0);
    br(32'h4, 1'b1);
    idle();
    chk("t2_pred_hold", {31'b0, o_buyruk_ongoru}, 32'd1);

    // 3: five taken resolves at idx 0, then a not-taken one
    res(1'b1, 1'b0);
    br(32'h0C, 1'b1); res(1'b1, 1'b0);
    br(32'h1C, 1'b1); res(1'b1, 1'b0);
    br(32'h3C, 1'b1); res(1'b1, 1'b0);
    br(32'h7C, 1'b1); res(1'b1, 1'b0);
    br(32'hFC, 1'b1); res(1'b0, 1'b1);
    br(32'hF8, 1'b1);

    // 4: fill the queue (ghr 3D,3A,34,28 -> 10)
    res(1'b1, 1'b0);
    br(32'h100, 1'b0);
    br(32'h100, 1'b0);
    br(32'h100, 1'b0);
    chk("t4_not_full_at_3", {31'b0, o_kuyruk_dolu}, 32'd0);
    br(32'h100, 1'b0);
    chk("t4_full_at_4", {31'b0, o_kuyruk_dolu}, 32'd1);
    drive(1'b1, 32'h100, 32'h0000_0063, 1'b0, 1'b0);
    chk("t4_drop_no_pulse", {31'b0, o_ongoru_gecerli}, 32'd0);
    chk("t4_still_full", {31'b0, o_kuyruk_dolu}, 32'd1);
    // idx 0x10 ^ ghr(0x10) = 0 -> counter 11 only if ghr was untouched
    drive(1'b1, 32'h40, 32'h0000_0063, 1'b1, 1'b0);
    exp_pred(1'b1);
    chk("t4_full_after_swap", {31'b0, o_kuyruk_dolu}, 32'd1);

    // 5: flush with same-cycle branch; ghr becomes 0x29
    res(1'b0, 1'b0);
    drive(1'b1, 32'h100, 32'h0000_0063, 1'b1, 1'b1);
    exp_mis_cyc.push_back(cyc);
    chk("t5_drop_no_pulse", {31'b0, o_ongoru_gecerli}, 32'd0);
    chk("t5_flushed", {31'b0, o_kuyruk_dolu}, 32'd0);
    res(1'b1, 1'b0);
    chk("t5_empty_resolve_no_pulse", {31'b0, o_ongoru_yanlis}, 32'd0);
    br(32'h74, 1'b1);
    br(32'h4C, 1'b1);

    // 6: reset mid-flight with resolves pending
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    check_reset_outputs("reset2");
    rst = 1'b0;
    br(32'h100, 1'b0);
    res(1'b0, 1'b0);
    br(32'hD0, 1'b0);
    res(1'b0, 1'b0);
    chk("t6_dolu", {31'b0, o_kuyruk_dolu}, 32'd0);

    idle(); idle(); idle();
    chk("pred_queue_drained", exp_pred_cyc.size(), 32'd0);
    chk("mispredict_queue_drained", exp_mis_cyc.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
